// File: rtl/model_loader.sv
// Byte-stream loader: parses header/base/length/data frames and issues one
// registered memory write per data byte, one clock after the byte is accepted.
module model_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [1:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              load_done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_HDR,
        S_BASE,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          tgt_q, tgt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   len_q, len_d;
    logic [DATA_W-1:0]   cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                xfer;

    // Ready depends only on state; the reset term keeps it low during the reset cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            in_ready = (state_q == S_HDR) || (state_q == S_BASE) ||
                       (state_q == S_LEN) || (state_q == S_DATA);
        end
    end

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_HDR: if (xfer) begin
                if (in_data[DATA_W-3:0] != '0) begin
                    state_d = S_ERROR;
                end else if (in_data[DATA_W-1 -: 2] == 2'b11) begin
                    state_d = S_DONE;
                end else begin
                    tgt_d   = in_data[DATA_W-1 -: 2];
                    state_d = S_BASE;
                end
            end
            S_BASE: if (xfer) begin
                base_d  = ADDR_W'(in_data);
                cnt_d   = '0;
                state_d = S_LEN;
            end
            S_LEN: if (xfer) begin
                len_d   = in_data;
                state_d = (in_data == '0) ? S_HDR : S_DATA;
            end
            S_DATA: if (xfer) begin
                we_d    = 1'b1;
                sel_d   = tgt_q;
                addr_d  = base_q + ADDR_W'(cnt_q);
                wdata_d = in_data;
                if (cnt_q == len_q - 1'b1) begin
                    state_d = S_HDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HDR;
            tgt_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_sel   = sel_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q == S_BASE) || (state_q == S_LEN) || (state_q == S_DATA);
    assign load_done = (state_q == S_DONE);
    assign err       = (state_q == S_ERROR);

endmodule

// File: tb/tb_model_loader.sv
// Bench for model_loader: a frame-parsing reference model checked every cycle,
// plus literal write-log expectations for each directed scenario.
module tb_model_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] mem_sel;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       busy;
    logic       load_done;
    logic       err;

    int checks = 0;
    int errors = 0;

    model_loader #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_sel  (mem_sel),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .busy     (busy),
        .load_done(load_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: position within the current frame, halted flags, and
    // the write the DUT must present one cycle after each accepted data byte.
    bit armed = 0;
    int pos = 0;
    int m_tgt = 0, m_base = 0, m_len = 0;
    bit m_done = 0, m_bad = 0;
    bit e_we = 0;
    int e_sel = 0, e_addr = 0, e_data = 0;

    always @(posedge clk) begin
        if (reset) begin
            armed = 1; pos = 0; m_done = 0; m_bad = 0;
            e_we = 0; e_sel = 0; e_addr = 0; e_data = 0;
        end else if (armed) begin
            e_we = 0;
            if (in_valid && !m_done && !m_bad) begin
                if (pos == 0) begin
                    if ((in_data % 64) != 0)      m_bad = 1;
                    else if (in_data / 64 == 3)   m_done = 1;
                    else begin m_tgt = in_data / 64; pos = 1; end
                end else if (pos == 1) begin
                    m_base = in_data; pos = 2;
                end else if (pos == 2) begin
                    m_len = in_data; pos = (in_data == 0) ? 0 : 3;
                end else begin
                    e_we = 1; e_sel = m_tgt;
                    e_addr = (m_base + pos - 3) % 256;
                    e_data = in_data;
                    pos = (pos - 3 == m_len - 1) ? 0 : pos + 1;
                end
            end
        end
    end

    int wlog[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) wlog.push_back({mem_sel, mem_addr, mem_wdata});
        if (armed) begin
            chk("in_ready", int'(in_ready), int'(!reset && !m_done && !m_bad));
            chk("mem_we", int'(mem_we), int'(e_we));
            chk("busy", int'(busy), int'(pos != 0 && !m_done && !m_bad));
            chk("load_done", int'(load_done), int'(m_done));
            chk("err", int'(err), int'(m_bad));
            if (e_we) begin
                chk("mem_sel", int'(mem_sel), e_sel);
                chk("mem_addr", int'(mem_addr), e_addr);
                chk("mem_wdata", int'(mem_wdata), e_data);
            end
        end
    end

    logic [7:0] txq[$];

    task automatic send_q();
        for (int k = 0; k < txq.size(); k++) begin
            bit acc = 0;
            bit rdy;
            in_data  = txq[k];
            in_valid = 1'b1;
            for (int t = 0; t < 50 && !acc; t++) begin
                @(negedge clk);
                rdy = in_ready;
                @(posedge clk);
                #1;
                if (rdy) acc = 1;
            end
            chk("accept", int'(acc), 1);
            if (!acc) break;
        end
        in_valid = 1'b0;
        txq.delete();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            in_data = in_data + 8'h37;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic log_entry(input string nm, input int idx, input int sel, input int addr, input int data);
        chk(nm, (idx < wlog.size()) ? wlog[idx] : -1, (sel << 16) | (addr << 8) | data);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", int'(in_ready), 1);
        chk("reset_outs", int'({mem_we, mem_sel, mem_addr, mem_wdata, busy, load_done, err}), 0);
        @(posedge clk); #1;

        // Instruction segment
        wlog.delete();
        txq = '{8'h00, 8'h00, 8'h03, 8'h05, 8'h04, 8'h02};
        send_q();
        idle(3);
        chk("t1_count", wlog.size(), 3);
        log_entry("t1_w0", 0, 0, 8'h00, 8'h05);
        log_entry("t1_w1", 1, 0, 8'h01, 8'h04);
        log_entry("t1_w2", 2, 0, 8'h02, 8'h02);
        chk("t1_busy", int'(busy), 0);

        // Neuron segment with stalls between data bytes
        wlog.delete();
        txq = '{8'h80, 8'h10, 8'h02, 8'hAA};
        send_q();
        idle(2);
        txq = '{8'hBB};
        send_q();
        idle(3);
        chk("t2_count", wlog.size(), 2);
        log_entry("t2_w0", 0, 2, 8'h10, 8'hAA);
        log_entry("t2_w1", 1, 2, 8'h11, 8'hBB);

        // Empty segment then a single-byte weight segment
        wlog.delete();
        txq = '{8'h00, 8'h20, 8'h00, 8'h40, 8'h00, 8'h01, 8'h7F};
        send_q();
        idle(3);
        chk("t3_count", wlog.size(), 1);
        log_entry("t3_w0", 0, 1, 8'h00, 8'h7F);

        // Weight segment wrapping past 0xFF, then end frame
        wlog.delete();
        txq = '{8'h40, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'hC0};
        send_q();
        @(negedge clk);
        chk("t4_done", int'(load_done), 1);
        chk("t4_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h00;
        repeat (5) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        idle(2);
        chk("t4_count", wlog.size(), 3);
        log_entry("t4_w0", 0, 1, 8'hFE, 8'h11);
        log_entry("t4_w1", 1, 1, 8'hFF, 8'h22);
        log_entry("t4_w2", 2, 1, 8'h00, 8'h33);
        chk("t4_done_held", int'(load_done), 1);

        // Malformed header
        pulse_reset();
        wlog.delete();
        txq = '{8'h05};
        send_q();
        in_valid = 1'b1; in_data = 8'hC0;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_err", int'(err), 1);
        chk("t5_done", int'(load_done), 0);
        chk("t5_ready", int'(in_ready), 0);
        chk("t5_count", wlog.size(), 0);
        @(posedge clk); #1;
        pulse_reset();
        @(negedge clk);
        chk("t5_err_clr", int'(err), 0);
        chk("t5_ready_back", int'(in_ready), 1);
        @(posedge clk); #1;

        // Reset in the middle of a segment
        wlog.delete();
        txq = '{8'h40, 8'h00, 8'h04, 8'h01, 8'h02};
        send_q();
        pulse_reset();
        idle(2);
        chk("t6_pre_count", wlog.size(), 2);
        log_entry("t6_w0", 0, 1, 8'h00, 8'h01);
        log_entry("t6_w1", 1, 1, 8'h01, 8'h02);
        wlog.delete();
        txq = '{8'h00, 8'h00, 8'h01, 8'h09};
        send_q();
        idle(3);
        chk("t6_post_count", wlog.size(), 1);
        log_entry("t6_w2", 0, 0, 8'h00, 8'h09);
        chk("t6_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
